// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage MIPS pipeline.
//
// Selects forwarded operands, runs the single-cycle ALU, and hosts a sequential
// 32-iteration unsigned MULTU/DIVU unit with the architectural HI/LO registers.
// Drives the registered EX/MEM pipeline boundary and raises a stall request
// while a multiply/divide is in progress.
//
// Ports:
//   i_Clk, Reset          clock (rising edge), asynchronous active-low reset
//   i_RD1, i_RD2          register operands from ID/EX
//   i_SignImm             sign-extended immediate; shamt = i_SignImm[10:6]
//   i_ALUSrc, i_ALUCtrl   SrcB select and operation code
//   i_RegDst, i_RegWrite, i_MemWrite, i_MemtoReg, i_WriteReg   controls to EX/MEM
//   i_ForwardA/B          00/11: RDx, 01: i_ResultW, 10: i_ALUOutM
//   i_ALUOutM, i_ResultW  forwarding sources
//   i_CLR                 insert a bubble into EX/MEM on this edge
//   o_Stall               combinational stall request to the hazard unit
//   o_ALUOut .. o_MemtoReg  registered EX/MEM outputs
//   o_HI, o_LO            architectural HI/LO
module execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic             i_Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] i_RD1,
  input  logic [WIDTH-1:0] i_RD2,
  input  logic [WIDTH-1:0] i_SignImm,
  input  logic             i_ALUSrc,
  input  logic [3:0]       i_ALUCtrl,
  input  logic             i_RegDst,
  input  logic             i_RegWrite,
  input  logic             i_MemWrite,
  input  logic [1:0]       i_MemtoReg,
  input  logic [4:0]       i_WriteReg,
  input  logic [1:0]       i_ForwardA,
  input  logic [1:0]       i_ForwardB,
  input  logic [WIDTH-1:0] i_ALUOutM,
  input  logic [WIDTH-1:0] i_ResultW,
  input  logic             i_CLR,
  output logic             o_Stall,
  output logic [WIDTH-1:0] o_ALUOut,
  output logic [WIDTH-1:0] o_WriteData,
  output logic [4:0]       o_WriteReg,
  output logic             o_RegDst,
  output logic             o_RegWrite,
  output logic             o_MemWrite,
  output logic [1:0]       o_MemtoReg,
  output logic [WIDTH-1:0] o_HI,
  output logic [WIDTH-1:0] o_LO
);

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_XOR = 4'b0011, OP_NOR = 4'b0100, OP_SLL = 4'b0101,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SRL = 4'b1000,
                         OP_SRA = 4'b1001, OP_MULTU = 4'b1010, OP_DIVU = 4'b1011,
                         OP_MFHI = 4'b1100, OP_MFLO = 4'b1101, OP_LUI = 4'b1110,
                         OP_SLTU = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_State;
  logic [4:0]       r_Count;
  logic [WIDTH-1:0] r_WorkHi;
  logic [WIDTH-1:0] r_WorkLo;
  logic [WIDTH-1:0] r_Operand;
  logic             r_IsDiv;
  logic [WIDTH-1:0] r_Hi;
  logic [WIDTH-1:0] r_Lo;

  logic [WIDTH-1:0] w_SrcA;
  logic [WIDTH-1:0] w_FwdB;
  logic [WIDTH-1:0] w_SrcB;
  logic [4:0]       w_Shamt;
  logic [WIDTH-1:0] w_AluResult;
  logic             w_IsMulDiv;
  logic [WIDTH:0]   w_Sum;
  logic [WIDTH:0]   w_Shift;
  logic [WIDTH-1:0] w_Diff;
  logic [WIDTH-1:0] w_StepHi;
  logic [WIDTH-1:0] w_StepLo;

  assign w_Shamt    = i_SignImm[10:6];
  assign w_IsMulDiv = (i_ALUCtrl == OP_MULTU) || (i_ALUCtrl == OP_DIVU);
  assign w_SrcB     = i_ALUSrc ? i_SignImm : w_FwdB;
  assign o_HI       = r_Hi;
  assign o_LO       = r_Lo;

  // Stall covers the IDLE cycle that accepts the op plus every BUSY cycle;
  // gated by Reset so it drops the instant reset is asserted.
  assign o_Stall = Reset && (((r_State == IDLE) && w_IsMulDiv) || (r_State == BUSY));

  // Forwarding muxes; select 11 falls back to the register operand.
  always_comb begin
    unique case (i_ForwardA)
      2'b01:   w_SrcA = i_ResultW;
      2'b10:   w_SrcA = i_ALUOutM;
      default: w_SrcA = i_RD1;
    endcase
    unique case (i_ForwardB)
      2'b01:   w_FwdB = i_ResultW;
      2'b10:   w_FwdB = i_ALUOutM;
      default: w_FwdB = i_RD2;
    endcase
  end

  // Single-cycle ALU. MULTU/DIVU produce no ALU result; they retire as 0.
  always_comb begin
    w_AluResult = '0;
    unique case (i_ALUCtrl)
      OP_AND:  w_AluResult = w_SrcA & w_SrcB;
      OP_OR:   w_AluResult = w_SrcA | w_SrcB;
      OP_ADD:  w_AluResult = w_SrcA + w_SrcB;
      OP_XOR:  w_AluResult = w_SrcA ^ w_SrcB;
      OP_NOR:  w_AluResult = ~(w_SrcA | w_SrcB);
      OP_SLL:  w_AluResult = w_SrcB << w_Shamt;
      OP_SUB:  w_AluResult = w_SrcA - w_SrcB;
      OP_SLT:  w_AluResult = {{(WIDTH-1){1'b0}}, ($signed(w_SrcA) < $signed(w_SrcB))};
      OP_SRL:  w_AluResult = w_SrcB >> w_Shamt;
      OP_SRA:  w_AluResult = $unsigned($signed(w_SrcB) >>> w_Shamt);
      OP_MFHI: w_AluResult = r_Hi;
      OP_MFLO: w_AluResult = r_Lo;
      OP_LUI:  w_AluResult = w_SrcB << 16;
      OP_SLTU: w_AluResult = {{(WIDTH-1){1'b0}}, (w_SrcA < w_SrcB)};
      default: w_AluResult = '0;
    endcase
  end

  // One iteration of the sequential unit.
  // MULTU: {WorkHi,WorkLo} starts as {0, multiplier}; add multiplicand when the
  // low bit is set, then shift the 65-bit result right by one.
  // DIVU (restoring): WorkHi is the partial remainder, WorkLo the dividend that
  // is shifted out MSB-first while quotient bits are shifted in. A zero divisor
  // naturally yields an all-ones quotient and remainder equal to the dividend.
  always_comb begin
    w_Sum   = {1'b0, r_WorkHi} + (r_WorkLo[0] ? {1'b0, r_Operand} : '0);
    w_Shift = {r_WorkHi, r_WorkLo[WIDTH-1]};
    w_Diff  = w_Shift[WIDTH-1:0] - r_Operand;
    if (r_IsDiv) begin
      if (w_Shift >= {1'b0, r_Operand}) begin
        w_StepHi = w_Diff;
        w_StepLo = {r_WorkLo[WIDTH-2:0], 1'b1};
      end else begin
        w_StepHi = w_Shift[WIDTH-1:0];
        w_StepLo = {r_WorkLo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_StepHi = w_Sum[WIDTH:1];
      w_StepLo = {w_Sum[0], r_WorkLo[WIDTH-1:1]};
    end
  end

  // Multiply/divide sequencer: accept in IDLE, 32 steps in BUSY, retire in DONE.
  always_ff @(posedge i_Clk or negedge Reset) begin
    if (!Reset) begin
      r_State   <= IDLE;
      r_Count   <= '0;
      r_WorkHi  <= '0;
      r_WorkLo  <= '0;
      r_Operand <= '0;
      r_IsDiv   <= 1'b0;
      r_Hi      <= '0;
      r_Lo      <= '0;
    end else begin
      unique case (r_State)
        IDLE: begin
          if (w_IsMulDiv) begin
            r_WorkHi  <= '0;
            r_WorkLo  <= w_SrcA;
            r_Operand <= w_SrcB;
            r_IsDiv   <= (i_ALUCtrl == OP_DIVU);
            r_Count   <= 5'd31;
            r_State   <= BUSY;
          end
        end
        BUSY: begin
          r_WorkHi <= w_StepHi;
          r_WorkLo <= w_StepLo;
          if (r_Count == 5'd0) begin
            r_Hi    <= w_StepHi;
            r_Lo    <= w_StepLo;
            r_State <= DONE;
          end else begin
            r_Count <= r_Count - 5'd1;
          end
        end
        DONE:    r_State <= IDLE;
        default: r_State <= IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register; stall or clear inserts an all-zero bubble.
  always_ff @(posedge i_Clk or negedge Reset) begin
    if (!Reset) begin
      o_ALUOut    <= '0;
      o_WriteData <= '0;
      o_WriteReg  <= '0;
      o_RegDst    <= 1'b0;
      o_RegWrite  <= 1'b0;
      o_MemWrite  <= 1'b0;
      o_MemtoReg  <= '0;
    end else if (o_Stall || i_CLR) begin
      o_ALUOut    <= '0;
      o_WriteData <= '0;
      o_WriteReg  <= '0;
      o_RegDst    <= 1'b0;
      o_RegWrite  <= 1'b0;
      o_MemWrite  <= 1'b0;
      o_MemtoReg  <= '0;
    end else begin
      o_ALUOut    <= w_AluResult;
      o_WriteData <= w_FwdB;
      o_WriteReg  <= i_WriteReg;
      o_RegDst    <= i_RegDst;
      o_RegWrite  <= i_RegWrite && !w_IsMulDiv;
      o_MemWrite  <= i_MemWrite;
      o_MemtoReg  <= i_MemtoReg;
    end
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline; consumes the ID/EX pipeline register outputs and drives a registered EX/MEM boundary.
- Contains:
  - operand forwarding muxes;
  - a single-cycle ALU;
  - a 32-iteration sequential unsigned multiply/divide unit with HI/LO registers;
  - a stall request back to the hazard unit, which holds the ID/EX register (WE_n) and upstream stages.

Parameters:
WIDTH, 32, datapath width; only 32 is supported (counter and HI/LO sized for 32).

Ports:
i_Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
i_RD1  in  32  register operand A from ID/EX
i_RD2  in  32  register operand B from ID/EX
i_SignImm  in  32  sign-extended immediate; shamt = i_SignImm[10:6]
i_ALUSrc  in  1  1: SrcB = i_SignImm, 0: SrcB = forwarded RD2
i_ALUCtrl  in  4  operation code (see Behaviour)
i_RegDst, i_RegWrite, i_MemWrite  in  1 each  control passed to EX/MEM
i_MemtoReg  in  2  control passed to EX/MEM
i_WriteReg  in  5  destination register number (already RegDst-resolved)
i_ForwardA, i_ForwardB  in  2 each  00: RDx, 01: i_ResultW, 10: i_ALUOutM, 11: RDx
i_ALUOutM  in  32  MEM-stage ALU result for forwarding
i_ResultW  in  32  WB-stage result for forwarding
i_CLR  in  1  insert bubble into EX/MEM on this edge
o_Stall  out  1  combinational; EX cannot retire this cycle
o_ALUOut  out  32  registered ALU result
o_WriteData  out  32  registered forwarded operand B (pre-ALUSrc mux)
o_WriteReg  out  5  registered destination
o_RegDst, o_RegWrite, o_MemWrite  out  1 each  registered controls
o_MemtoReg  out  2  registered control
o_HI, o_LO  out  32 each  architectural HI/LO

Behaviour:
- Reset (async, Reset=0):
  - all EX/MEM outputs, HI, LO, the iteration counter and the working registers go to 0;
  - FSM goes to IDLE; o_Stall=0.
  - Reset asserted mid-operation aborts the operation; HI/LO read 0 afterwards.
- Operands:
  - SrcA = forward mux A;
  - FwdB = forward mux B;
  - SrcB = i_ALUSrc ? i_SignImm : FwdB.
- ALUCtrl codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR; 0110 SUB.
  - 0101 SLL: SrcB << shamt.
  - 0111 SLT: signed, result 1/0.
  - 1000 SRL: SrcB >> shamt, logical.
  - 1001 SRA: SrcB >>> shamt.
  - 1010 MULTU; 1011 DIVU.
  - 1100 MFHI: result = HI; 1101 MFLO: result = LO.
  - 1110 LUI: SrcB << 16.
  - 1111 SLTU: unsigned, result 1/0.
- Arithmetic: ADD/SUB wrap modulo 2^32, no overflow trap.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, ALUCtrl is MULTU/DIVU: latch SrcA/SrcB and the op, counter=31, go to BUSY; o_Stall=1 this cycle.
  - BUSY: one shift-add (MULTU) or restoring shift-subtract (DIVU) step per cycle; o_Stall=1.
  - BUSY at counter=0: final step; write HI/LO on this edge; go to DONE.
  - DONE: o_Stall=0; the op retires into EX/MEM this edge; always go to IDLE. A MULTU/DIVU still present at the input in DONE does not restart.
  - Total: 33 stall cycles per MULTU/DIVU; HI/LO are visible from the DONE cycle onward.
- MULTU result: {HI,LO} = SrcA*SrcB, 64-bit unsigned.
- DIVU result: LO = quotient, HI = remainder.
  - Divide by zero: LO=32'hFFFFFFFF, HI=dividend. No exception.
- MFHI/MFLO directly after MULTU/DIVU retires read the new values; there is no extra interlock.
- EX/MEM register, priority in order:
  - Reset.
  - Else, o_Stall=1 or i_CLR=1: bubble. o_RegWrite=0, o_MemWrite=0; all other EX/MEM outputs=0.
  - Else: load the computed values.
- MULTU/DIVU always retire with o_RegWrite forced to 0, regardless of i_RegWrite.
- i_CLR does not abort a BUSY operation; i_CLR in DONE bubbles the retire, but HI/LO are already written.
- Pass-through ops (non MULTU/DIVU) have latency 1: result at o_ALUOut on the edge after presentation.
- Forwarding select 11 behaves as 00.

Test Plan:
- Reset: hold Reset=0 with arbitrary inputs -> all outputs 0, o_Stall=0; release -> remains 0 until first valid edge.
- ALU sweep:
  - ADD 0x7FFFFFFF+1 -> o_ALUOut=0x80000000.
  - SLT 0xFFFFFFFF,1 -> 1; SLTU -> 0.
  - SRA 0x80000000 shamt 4 -> 0xF8000000.
  - LUI imm 0x1234 -> 0x12340000.
- Forwarding: i_ForwardA=10, i_ALUOutM=5, i_ForwardB=01, i_ResultW=7, ADD -> o_ALUOut=12, o_WriteData=7.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, op held while o_Stall -> o_Stall high exactly 33 cycles, HI=0xFFFFFFFE, LO=1, bubbles during the stall, retire with o_RegWrite=0, next-cycle MFHI -> 0xFFFFFFFE.
- DIVU 100/7 -> LO=14, HI=2. DIVU 9/0 -> LO=0xFFFFFFFF, HI=9.
- Reset asserted at BUSY cycle 10 -> o_Stall=0 immediately, HI=LO=0; i_CLR during a normal ADD -> o_RegWrite=0, o_ALUOut=0.
